// File: rtl/glitc_conf_shifter.sv
`default_nettype none
// ============================================================================
//  Module   : glitc_conf_shifter
//  Purpose  : WISHBONE-controlled serial configuration shifter for up to four
//             GLITC devices. Words written to the DATA register are queued in
//             a 4-deep FIFO and shifted out MSB first on DIN, clocked by the
//             CCLK line of the currently selected target.
//  Ports    : clk_i, rst_n_i         - system clock, async active-low reset
//             cyc_i/stb_i/we_i/adr_i/dat_i/sel_i/dat_o/ack_o/err_o/rty_o
//                                    - WISHBONE slave (adr_i[4:2] decoded:
//                                      0 = DATA, 1 = CTRL/STAT)
//             CCLK[3:0]              - per-target configuration clock
//             DIN                    - shared serial configuration data
//             INIT_B[3:0], DONE[3:0] - per-target status, synchronous to clk_i
//  Revision : 1.0 - initial release
// ============================================================================
module glitc_conf_shifter #(
    parameter int CCLK_DIV = 2
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        cyc_i,
    input  logic        stb_i,
    input  logic        we_i,
    input  logic [4:0]  adr_i,
    input  logic [31:0] dat_i,
    input  logic [3:0]  sel_i,
    output logic [31:0] dat_o,
    output logic        ack_o,
    output logic        err_o,
    output logic        rty_o,
    output logic [3:0]  CCLK,
    output logic        DIN,
    input  logic [3:0]  INIT_B,
    input  logic [3:0]  DONE
);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_LOW   = 2'd1;
    localparam logic [1:0] c_ST_HIGH  = 2'd2;
    localparam logic [1:0] c_ST_ERROR = 2'd3;

    localparam logic [2:0] c_ADR_DATA = 3'd0;
    localparam logic [2:0] c_ADR_CTRL = 3'd1;
    localparam logic [3:0] c_DIV_LAST = 4'(CCLK_DIV - 1);
    localparam logic [2:0] c_FIFO_DEPTH = 3'd4;

    // State and datapath registers
    logic [1:0]  r_state;
    logic [1:0]  w_state_next;
    logic [3:0]  r_div_cnt;
    logic [4:0]  r_bit_cnt;
    logic [31:0] r_shift;
    logic [1:0]  r_target;
    logic        r_error;

    // FIFO
    logic [31:0] r_mem [0:3];
    logic [1:0]  r_wr_ptr;
    logic [1:0]  r_rd_ptr;
    logic [2:0]  r_count;

    // Decode and control
    logic        w_access;
    logic        w_data_wr;
    logic        w_ctrl_wr;
    logic        w_abort;
    logic        w_shifting;
    logic        w_init_fail;
    logic        w_div_done;
    logic        w_fifo_empty;
    logic        w_word_end;
    logic        w_pop;
    logic        w_shift;
    logic        w_push;
    logic        w_flush;
    logic        w_busy;
    logic [31:0] w_stat;
    logic        w_unused;

    assign w_access     = cyc_i & stb_i;
    assign w_data_wr    = w_access & we_i & (adr_i[4:2] == c_ADR_DATA);
    assign w_ctrl_wr    = w_access & we_i & (adr_i[4:2] == c_ADR_CTRL);
    assign w_abort      = w_ctrl_wr & dat_i[4];
    assign w_shifting   = (r_state == c_ST_LOW) | (r_state == c_ST_HIGH);
    assign w_init_fail  = w_shifting & ~INIT_B[r_target];
    assign w_div_done   = (r_div_cnt == c_DIV_LAST);
    assign w_fifo_empty = (r_count == 3'd0);
    assign w_word_end   = (r_state == c_ST_HIGH) & w_div_done;

    // Abort and an INIT_B failure both override any shifting activity.
    assign w_pop   = ~w_abort & ~w_init_fail & ~w_fifo_empty &
                     ((r_state == c_ST_IDLE) | (w_word_end & (r_bit_cnt == 5'd0)));
    assign w_shift = ~w_abort & ~w_init_fail & w_word_end & (r_bit_cnt != 5'd0);

    // A full FIFO still takes a word when a pop frees a slot in the same
    // cycle. Writes racing an INIT_B failure are refused since the FIFO is
    // about to be flushed.
    assign w_push  = w_data_wr & (r_state != c_ST_ERROR) & ~w_init_fail &
                     ((r_count < c_FIFO_DEPTH) | w_pop);
    assign w_flush = w_abort | w_init_fail;

    assign w_busy  = (r_state != c_ST_IDLE);
    assign w_stat  = {8'h00, DONE, INIT_B, 3'b000, r_error, 3'b000, w_busy,
                      1'b0, r_count, 2'b00, r_target};

    // WISHBONE responses
    assign rty_o = w_data_wr & ~w_push;
    assign ack_o = w_access & ~rty_o;
    assign err_o = 1'b0;
    assign dat_o = (adr_i[4:2] == c_ADR_CTRL) ? w_stat : 32'h0000_0000;

    assign DIN      = r_shift[31];
    assign w_unused = ^{sel_i, adr_i[1:0]};

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (!w_abort && !w_fifo_empty) begin
                    w_state_next = c_ST_LOW;
                end
            end
            c_ST_LOW: begin
                if (w_abort) begin
                    w_state_next = c_ST_IDLE;
                end else if (w_init_fail) begin
                    w_state_next = c_ST_ERROR;
                end else if (w_div_done) begin
                    w_state_next = c_ST_HIGH;
                end
            end
            c_ST_HIGH: begin
                if (w_abort) begin
                    w_state_next = c_ST_IDLE;
                end else if (w_init_fail) begin
                    w_state_next = c_ST_ERROR;
                end else if (w_div_done) begin
                    // Chain straight into the next queued word to avoid a gap.
                    if (r_bit_cnt != 5'd0 || !w_fifo_empty) begin
                        w_state_next = c_ST_LOW;
                    end else begin
                        w_state_next = c_ST_IDLE;
                    end
                end
            end
            c_ST_ERROR: begin
                if (w_abort) begin
                    w_state_next = c_ST_IDLE;
                end
            end
            default: w_state_next = c_ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        CCLK = 4'b0000;
        if (r_state == c_ST_HIGH) begin
            CCLK[r_target] = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Half-period divider, bit counter and shift register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_div_cnt <= 4'd0;
        end else if (w_state_next != r_state || !w_shifting) begin
            r_div_cnt <= 4'd0;
        end else begin
            r_div_cnt <= r_div_cnt + 4'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_shift   <= 32'h0000_0000;
            r_bit_cnt <= 5'd0;
        end else if (w_flush) begin
            r_shift   <= 32'h0000_0000;
            r_bit_cnt <= 5'd0;
        end else if (w_pop) begin
            r_shift   <= r_mem[r_rd_ptr];
            r_bit_cnt <= 5'd31;
        end else if (w_shift) begin
            r_shift   <= {r_shift[30:0], 1'b0};
            r_bit_cnt <= r_bit_cnt - 5'd1;
        end
    end

    // ------------------------------------------------------------------
    // Target select and sticky error flag
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_target <= 2'd0;
        end else if (w_ctrl_wr && r_state == c_ST_IDLE) begin
            r_target <= dat_i[1:0];
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_error <= 1'b0;
        end else if (w_abort) begin
            r_error <= 1'b0;
        end else if (w_init_fail) begin
            r_error <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // 4-word FIFO
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_wr_ptr <= 2'd0;
            r_rd_ptr <= 2'd0;
            r_count  <= 3'd0;
        end else if (w_flush) begin
            r_wr_ptr <= 2'd0;
            r_rd_ptr <= 2'd0;
            r_count  <= 3'd0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 2'd1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 2'd1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 3'd1;
                2'b01:   r_count <= r_count - 3'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < 4; i++) begin
                r_mem[i] <= 32'h0000_0000;
            end
        end else if (w_push && !w_flush) begin
            r_mem[r_wr_ptr] <= dat_i;
        end
    end

endmodule
`default_nettype wire

// File: doc/glitc_conf_shifter.md
GLITC_CONF_SHIFTER -- requirements
Module: glitc_conf_shifter

Interface
REQ-001 SHALL have parameter CCLK_DIV, default 2: CCLK half-period in clk_i cycles, legal range 1..15.
REQ-002 SHALL have port clk_i, input, 1 bit: single system clock; all logic runs on its rising edge.
REQ-003 SHALL have port rst_n_i, input, 1 bit: reset, asynchronous, active-low.
REQ-004 SHALL have WISHBONE slave ports cyc_i, stb_i, we_i (1 each), adr_i (5, byte address), dat_i (32), sel_i (4, ignored), dat_o (32), ack_o, err_o, rty_o (1 each).
REQ-005 SHALL have port CCLK, output, 4 bits: per-GLITC configuration clock; only the selected target toggles.
REQ-006 SHALL have port DIN, output, 1 bit: serial configuration data, shared by all GLITCs.
REQ-007 SHALL have port INIT_B, input, 4 bits: per-GLITC INIT_B, already synchronous to clk_i.
REQ-008 SHALL have port DONE, input, 4 bits: per-GLITC DONE, already synchronous to clk_i.

Function
REQ-009 SHALL decode adr_i[4:2]: 0 = DATA (write-only, reads 0); 1 = CTRL/STAT; other addresses read 0, writes ignored.
REQ-010 SHALL push dat_i into a 4-word FIFO on a DATA write when FIFO count < 4, with ack_o=1 that cycle.
REQ-011 SHALL, on a DATA write with FIFO full or ERROR state, drop the word, assert rty_o=1 and ack_o=0 that cycle.
REQ-012 SHALL assert ack_o = cyc_i & stb_i combinationally for all other accesses; err_o SHALL be 0 always.
REQ-013 SHALL, on CTRL write: bits[1:0] set target only when state is IDLE; bit 4 = abort (flush FIFO, clear error, go IDLE, honoured in any state).
REQ-014 SHALL return on STAT read: [1:0] target, [6:4] FIFO count 0..4, [8] busy (state != IDLE), [12] error, [19:16] INIT_B, [23:20] DONE, rest 0.
REQ-015 SHALL implement states IDLE, LOW, HIGH, ERROR.
REQ-016 IDLE: CCLK all 0; when FIFO non-empty, pop word into 32-bit shift register, drive DIN = bit 31, bit counter = 31, go LOW.
REQ-017 LOW: CCLK[target]=0 for CCLK_DIV cycles, then go HIGH.
REQ-018 HIGH: CCLK[target]=1 for CCLK_DIV cycles; at exit, if bit counter > 0, shift left, DIN = next bit, decrement, go LOW.
REQ-019 At HIGH exit with bit counter 0: if FIFO non-empty, pop next word, DIN = its bit 31, go LOW (no gap); else go IDLE.
REQ-020 One word SHALL occupy exactly 64*CCLK_DIV clk_i cycles on CCLK; bits transmitted MSB first; DIN changes only while CCLK[target] is low.
REQ-021 SHALL, if INIT_B[target]=0 in LOW or HIGH, go ERROR next cycle: CCLK 0, set error, flush FIFO; remain until abort.
REQ-022 SHALL treat simultaneous DATA push and pop as count unchanged; push accepted when full only if pop occurs same cycle.
REQ-023 SHALL treat abort coincident with DATA write as abort winning (word dropped, ack_o=1).
REQ-024 Non-target CCLK bits SHALL remain 0 at all times.

Reset
REQ-025 On rst_n_i=0, asynchronously: state IDLE, FIFO empty, target 0, error 0, shift register 0, CCLK=4'b0000, DIN=0.
REQ-026 Reset assertion mid-word SHALL discard the word with no further CCLK edges; after release, idle until new DATA write.

Verification
REQ-027 CCLK_DIV=2, target 1, write DATA 0xA5000001 -> CCLK[1] 32 pulses, 4-cycle period, DIN sequence 1,0,1,0,0,1,0,1,0...0,1; busy returns 0 after 128 cycles.
REQ-028 Write 5 DATA words back-to-back while shifting -> 5th gets rty_o=1; STAT count reads 4; after drain, 4 words sent with no CCLK gap.
REQ-029 Drive INIT_B[1]=0 mid-word -> ERROR, STAT[12]=1, count 0, CCLK=0, DATA write rty_o=1; CTRL write 0x10 -> IDLE, error 0.
REQ-030 Write CTRL target=3 while busy on target 1 -> target stays 1; after IDLE, rewrite -> target 3, only CCLK[3] toggles.
REQ-031 Assert rst_n_i at bit 10 of a word -> CCLK and DIN 0 immediately; STAT reads 0x0 for busy, count, error after release.
REQ-032 CCLK_DIV=1 -> word takes 64 cycles, CCLK toggles every cycle, two queued words produce 64 contiguous pulses.
